// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage state encoding and constants shared with the ID/EXE stages
package fetch_pkg;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP, F_FULL} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem handshake, hazard/redirect inputs and IF/ID register outputs
interface fetch_if #(parameter int ADDR_W = 32, parameter int INSTR_W = 32) ();
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic hazard_detected;
  logic branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc,
    input imem_rvalid, imem_rdata, hazard_detected, branch_taken, branch_target
  );
  modport slave (
    input imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc,
    output imem_rvalid, imem_rdata, hazard_detected, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc} holding slot for a response that arrives during a stall
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic unload,
  input  logic clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic full,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);
  // clear wipes the entry (redirect); unload just frees it after it moved into IF/ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      instr <= INSTR_W'(NOP_INSTR);
      pc <= '0;
    end else if (clear) begin
      full <= 1'b0;
      instr <= INSTR_W'(NOP_INSTR);
      pc <= '0;
    end else if (unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      instr <= in_instr;
      pc <= in_pc;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, fetching over req/rvalid and driving the IF/ID register
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, redir, redir_n, pc_inc, ipc, ipc_n, skid_pc;
  logic [INSTR_W-1:0] ins, ins_n, skid_instr;
  logic v, v_n, accept, skid_load, skid_unload, skid_clear, skid_full;
  assign pc_inc = pc + ADDR_W'(PC_STEP);
  assign accept = !bus.hazard_detected || !v;
  assign bus.imem_req = (state == F_WAIT) || (state == F_DROP);
  assign bus.imem_addr = pc;
  assign bus.if_id_valid = v;
  assign bus.if_id_instr = ins;
  assign bus.if_id_pc = ipc;
  fetch_skid_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .unload(skid_unload), .clear(skid_clear),
    .in_instr(bus.imem_rdata), .in_pc(pc_inc), .full(skid_full), .instr(skid_instr), .pc(skid_pc)
  );
  // state, PC, pending redirect and the IF/ID register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F_IDLE;
      pc <= RESET_PC;
      redir <= '0;
      v <= 1'b0;
      ins <= INSTR_W'(NOP_INSTR);
      ipc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      redir <= redir_n;
      v <= v_n;
      ins <= ins_n;
      ipc <= ipc_n;
    end
  end
  // redirect beats stall; an in-flight request is never abandoned, its response is dropped instead
  always_comb begin
    state_n = state;
    pc_n = pc;
    redir_n = redir;
    v_n = v;
    ins_n = ins;
    ipc_n = ipc;
    skid_load = 1'b0;
    skid_unload = 1'b0;
    skid_clear = 1'b0;
    if (bus.branch_taken) begin
      v_n = 1'b0;
      ins_n = INSTR_W'(NOP_INSTR);
      ipc_n = '0;
      skid_clear = 1'b1;
      if ((state == F_WAIT || state == F_DROP) && !bus.imem_rvalid) begin
        redir_n = bus.branch_target;
        state_n = F_DROP;
      end else begin
        pc_n = bus.branch_target;
        state_n = F_WAIT;
      end
    end else begin
      unique case (state)
        F_IDLE: state_n = F_WAIT;
        F_WAIT:
          if (bus.imem_rvalid) begin
            pc_n = pc_inc;
            if (accept) begin
              v_n = 1'b1;
              ins_n = bus.imem_rdata;
              ipc_n = pc_inc;
            end else begin
              skid_load = 1'b1;
              state_n = F_FULL;
            end
          end else if (accept) v_n = 1'b0;
        F_FULL:
          if (!bus.hazard_detected && skid_full) begin
            v_n = 1'b1;
            ins_n = skid_instr;
            ipc_n = skid_pc;
            skid_unload = 1'b1;
            state_n = F_WAIT;
          end
        F_DROP:
          if (bus.imem_rvalid) begin
            pc_n = redir;
            state_n = F_WAIT;
          end
        default: state_n = F_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch scenarios with a scoreboard of expected IF/ID entries
module tb_fetch_stage;
  import fetch_pkg::*;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  logic clk, rst, mem_en;
  int lat, cnt, checks, failures;
  exp_t q[$];
  fetch_if bus ();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction
  assign bus.imem_rvalid = mem_en && bus.imem_req && (cnt >= lat);
  assign bus.imem_rdata = bus.imem_rvalid ? data_of(bus.imem_addr) : 32'h0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (bus.imem_req && bus.imem_rvalid) cnt <= 0;
    else if (bus.imem_req && mem_en) cnt <= cnt + 1;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] a);
    q.push_back('{data_of(a), a + 32'd4});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    logic pv, ph;
    exp_t e;
    pv = 0;
    ph = 0;
    forever begin
      @(negedge clk);
      if (bus.if_id_valid && (!pv || !ph)) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL if_id_unexpected got pc=%h instr=%h required=none", bus.if_id_pc, bus.if_id_instr);
        end else begin
          e = q.pop_front();
          chk("sb_instr", bus.if_id_instr, e.instr);
          chk("sb_pc", bus.if_id_pc, e.pc);
        end
      end
      pv = bus.if_id_valid;
      ph = bus.hazard_detected;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    mem_en = 0;
    lat = 0;
    bus.hazard_detected = 0;
    bus.branch_taken = 0;
    bus.branch_target = 0;
    tick(2);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_valid", 32'(bus.if_id_valid), 0);
    chk("rst_instr", bus.if_id_instr, NOP_INSTR);
    chk("rst_pc", bus.if_id_pc, 0);
    chk("rst_addr", bus.imem_addr, 0);
    rst = 0;
    for (int a = 0; a <= 16; a += 4) push(32'(a));
    mem_en = 1;
    tick(1);
    chk("zw_req", 32'(bus.imem_req), 1);
    chk("zw_addr0", bus.imem_addr, 0);
    tick(5);
    chk("zw_valid", 32'(bus.if_id_valid), 1);
    chk("zw_lastpc", bus.if_id_pc, 32'h14);
    chk("zw_addr", bus.imem_addr, 32'h14);
    mem_en = 0;
    tick(1);
    chk("zw_drain", 32'(q.size()), 0);
    chk("mid_req", 32'(bus.imem_req), 1);
    chk("mid_addr", bus.imem_addr, 32'h14);
    #2 rst = 1;
    #1;
    chk("arst_req", 32'(bus.imem_req), 0);
    chk("arst_valid", 32'(bus.if_id_valid), 0);
    chk("arst_addr", bus.imem_addr, 0);
    chk("arst_pc", bus.if_id_pc, 0);
    tick(1);
    rst = 0;
    lat = 2;
    mem_en = 1;
    push(0);
    tick(1);
    chk("post_rst_req", 32'(bus.imem_req), 1);
    chk("post_rst_addr", bus.imem_addr, 0);
    tick(1);
    chk("slow_addr1", bus.imem_addr, 0);
    chk("slow_valid1", 32'(bus.if_id_valid), 0);
    tick(1);
    chk("slow_addr2", bus.imem_addr, 0);
    chk("slow_valid2", 32'(bus.if_id_valid), 0);
    tick(1);
    chk("slow_valid", 32'(bus.if_id_valid), 1);
    chk("slow_pc", bus.if_id_pc, 4);
    chk("slow_next_addr", bus.imem_addr, 4);
    bus.hazard_detected = 1;
    push(4);
    tick(3);
    chk("full_req", 32'(bus.imem_req), 0);
    chk("full_hold_valid", 32'(bus.if_id_valid), 1);
    chk("full_hold_pc", bus.if_id_pc, 4);
    tick(2);
    chk("full_req2", 32'(bus.imem_req), 0);
    chk("full_hold_pc2", bus.if_id_pc, 4);
    bus.hazard_detected = 0;
    tick(1);
    chk("unskid_pc", bus.if_id_pc, 8);
    chk("unskid_instr", bus.if_id_instr, data_of(4));
    chk("unskid_req", 32'(bus.imem_req), 1);
    chk("unskid_addr", bus.imem_addr, 8);
    bus.branch_taken = 1;
    bus.branch_target = 32'h40;
    tick(1);
    bus.branch_taken = 0;
    chk("drop_valid", 32'(bus.if_id_valid), 0);
    chk("drop_req", 32'(bus.imem_req), 1);
    chk("drop_addr", bus.imem_addr, 8);
    tick(2);
    chk("redir_addr", bus.imem_addr, 32'h40);
    chk("redir_req", 32'(bus.imem_req), 1);
    chk("redir_valid", 32'(bus.if_id_valid), 0);
    push(32'h40);
    tick(3);
    chk("redir_data_valid", 32'(bus.if_id_valid), 1);
    chk("redir_data_pc", bus.if_id_pc, 32'h44);
    bus.hazard_detected = 1;
    tick(3);
    chk("full2_req", 32'(bus.imem_req), 0);
    chk("full2_pc", bus.if_id_pc, 32'h44);
    bus.branch_taken = 1;
    bus.branch_target = 32'h80;
    tick(1);
    bus.branch_taken = 0;
    chk("flush_valid", 32'(bus.if_id_valid), 0);
    chk("flush_req", 32'(bus.imem_req), 1);
    chk("flush_addr", bus.imem_addr, 32'h80);
    tick(1);
    chk("flush_addr2", bus.imem_addr, 32'h80);
    bus.hazard_detected = 0;
    push(32'h80);
    tick(2);
    chk("flush_next_valid", 32'(bus.if_id_valid), 1);
    chk("flush_next_pc", bus.if_id_pc, 32'h84);
    lat = 0;
    bus.branch_taken = 1;
    bus.branch_target = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC);
    tick(1);
    bus.branch_taken = 0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_flush_valid", 32'(bus.if_id_valid), 0);
    tick(1);
    chk("wrap_pc", bus.if_id_pc, 0);
    chk("wrap_next_addr", bus.imem_addr, 0);
    mem_en = 0;
    tick(2);
    chk("final_drain", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
